// File: rtl/switch_debouncer_pkg.sv
// Shared constants for the slide-switch conditioning path.
package switch_pkg;

    localparam int SWT_WIDTH       = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int DEBOUNCE_SIM    = 4;
    localparam int DEBOUNCE_HW     = 1000000;  // 10 ms at 100 MHz

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch word bundle: raw pins in, debounced word and edge pulses out.
interface switch_debouncer_if #(
    parameter int WIDTH = 8
);

    logic [WIDTH-1:0] swt_raw;
    logic [WIDTH-1:0] swt_db;
    logic [WIDTH-1:0] swt_rise;
    logic [WIDTH-1:0] swt_fall;
    logic             changed;

    modport master (
        output swt_raw,
        input  swt_db,
        input  swt_rise,
        input  swt_fall,
        input  changed
    );

    modport slave (
        input  swt_raw,
        output swt_db,
        output swt_rise,
        output swt_fall,
        output changed
    );

endinterface

// File: rtl/switch_debouncer_debounce_bit.sv
// One switch bit: synchroniser chain, stability counter, debounced flop and edge pulses.
module debounce_bit
    import switch_pkg::*;
#(
    parameter int   SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_HW,
    parameter logic RESET_BIT       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db,
    output logic rise,
    output logic fall,
    output logic accept
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_p;
    logic                   sync_out;
    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       cnt_nxt;

    // Synchroniser stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p <= '0;
        end else begin
            sync_p <= {sync_p[SYNC_STAGES-2:0], raw};
        end
    end

    assign sync_out = sync_p[SYNC_STAGES-1];

    // Any return to the accepted level drops the partial count
    always_comb begin
        cnt_nxt = '0;
        accept  = 1'b0;
        if (sync_out != db) begin
            if (cnt == CNT_LAST) begin
                accept = 1'b1;
            end else begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end
    end

    // Filter / output stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= '0;
            db   <= RESET_BIT;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            rise <= accept & sync_out;
            fall <= accept & ~sync_out;
            if (accept) begin
                db <= sync_out;
            end
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces every slide switch independently and flags any accepted change.
module switch_debouncer
    import switch_pkg::*;
#(
    parameter int               WIDTH           = SWT_WIDTH,
    parameter int               SYNC_STAGES     = SYNC_STAGES_DEF,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_HW,
    parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
    input  logic            clk,
    input  logic            rst,
    switch_debouncer_if.slave bus
);

    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] accept;
    logic             changed_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_BIT       (RESET_VAL[i])
        ) u_bit (
            .clk    (clk),
            .rst    (rst),
            .raw    (bus.swt_raw[i]),
            .db     (db[i]),
            .rise   (rise[i]),
            .fall   (fall[i]),
            .accept (accept[i])
        );
    end

    // Registered from the accept strobes so it lines up with the per-bit pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= |accept;
        end
    end

    assign bus.swt_db   = db;
    assign bus.swt_rise = rise;
    assign bus.swt_fall = fall;
    assign bus.changed  = changed_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
module tb_switch_debouncer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    typedef struct {
        int         cyc;
        logic [7:0] db;
        logic [7:0] rise;
        logic [7:0] fall;
    } ev_t;

    ev_t sb_q[$];

    switch_debouncer_if #(.WIDTH(8)) sw ();

    switch_debouncer #(
        .WIDTH           (8),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .RESET_VAL       (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (sw)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive a new raw word on a falling edge; it is sampled on the next rising
    // edge k and must appear on edge k+5, seen here at cyc+6.
    task automatic drive_expect(input logic [7:0] val, input logic [7:0] r, input logic [7:0] f);
        @(negedge clk);
        sw.swt_raw = val;
        sb_q.push_back('{cyc + 6, val, r, f});
        repeat (10) @(negedge clk);
    endtask

    // Monitor: any pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!rst && (sw.changed || (|sw.swt_rise) || (|sw.swt_fall))) begin
            if (sb_q.size() == 0) begin
                check("unexpected_pulse", {8'h0, sw.swt_rise, sw.swt_fall, 7'h0, sw.changed}, 32'h0);
            end else begin
                ev_t e;
                e = sb_q.pop_front();
                check("ev_cycle",   32'(cyc),     32'(e.cyc));
                check("ev_swt_db",  32'(sw.swt_db),   32'(e.db));
                check("ev_rise",    32'(sw.swt_rise), 32'(e.rise));
                check("ev_fall",    32'(sw.swt_fall), 32'(e.fall));
                check("ev_changed", 32'(sw.changed),  32'h1);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sw.swt_raw = 8'hFF;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_swt_db",   32'(sw.swt_db),   32'h00);
        check("rst_rise",     32'(sw.swt_rise), 32'h00);
        check("rst_fall",     32'(sw.swt_fall), 32'h00);
        check("rst_changed",  32'(sw.changed),  32'h0);

        // Power-up: switches held high through reset count as a change
        rst = 1'b0;
        sb_q.push_back('{cyc + 6, 8'hFF, 8'hFF, 8'h00});
        repeat (10) @(negedge clk);
        check("pwrup_swt_db", 32'(sw.swt_db), 32'hFF);

        // Clean step 00 -> 05
        drive_expect(8'h00, 8'h00, 8'hFF);
        drive_expect(8'h05, 8'h05, 8'h00);
        check("step_swt_db", 32'(sw.swt_db), 32'h05);

        // Glitch: bit3 high for 3 samples only
        @(negedge clk);
        sw.swt_raw = 8'h0D;
        repeat (3) @(negedge clk);
        sw.swt_raw = 8'h05;
        repeat (10) @(negedge clk);
        check("glitch_swt_db", 32'(sw.swt_db), 32'h05);

        // Bounce on bit0: runs of 2 never qualify, final hold does
        drive_expect(8'h04, 8'h00, 8'h01);
        for (int i = 0; i < 20; i++) begin
            sw.swt_raw = {7'b0000010, ((i / 2) % 2 == 0)};
            @(negedge clk);
        end
        check("bounce_hold_swt_db", 32'(sw.swt_db), 32'h04);
        sw.swt_raw = 8'h05;
        sb_q.push_back('{cyc + 6, 8'h05, 8'h01, 8'h00});
        repeat (10) @(negedge clk);

        // Simultaneous rise and fall on different bits
        drive_expect(8'h0F, 8'h0A, 8'h00);
        drive_expect(8'hF0, 8'hF0, 8'h0F);
        check("simul_swt_db", 32'(sw.swt_db), 32'hF0);

        // Reset mid-count discards the partial count
        drive_expect(8'h00, 8'h00, 8'hF0);
        @(negedge clk);
        sw.swt_raw = 8'h80;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_swt_db",  32'(sw.swt_db),   32'h00);
        check("midrst_rise",    32'(sw.swt_rise), 32'h00);
        check("midrst_fall",    32'(sw.swt_fall), 32'h00);
        check("midrst_changed", 32'(sw.changed),  32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb_q.push_back('{cyc + 6, 8'h80, 8'h80, 8'h00});
        repeat (4) @(negedge clk);
        check("midrst_early_swt_db", 32'(sw.swt_db), 32'h00);
        repeat (8) @(negedge clk);
        check("midrst_final_swt_db", 32'(sw.swt_db), 32'h80);

        repeat (5) @(negedge clk);
        check("sb_drain", 32'(sb_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
